// File: rtl/vending_machine.sv
// Three-item coin-operated vending controller: credit accumulation, vend with change,
// cancel refund, per-item stock tracking and a registered low-stock flag.
module vending_machine #(
  parameter int PRICE_A    = 15,
  parameter int PRICE_B    = 20,
  parameter int PRICE_C    = 25,
  parameter int INIT_STOCK = 3,
  parameter int LOW_THRESH = 1,
  parameter int MAX_CREDIT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] coin_in,
  input  logic [1:0] select_item,
  input  logic       cancel,
  output logic       dispense_A,
  output logic       dispense_B,
  output logic       dispense_C,
  output logic       refund,
  output logic [7:0] change_out,
  output logic       low_stock
);

  typedef enum logic {IDLE, CREDIT} state_t;

  state_t     state_reg, state_next;
  logic [7:0] credit_reg, credit_next;
  logic [7:0] stock_reg [3];
  logic [7:0] stock_next [3];
  logic [2:0] dispense_reg, dispense_next;
  logic       refund_reg, refund_next;
  logic [7:0] change_reg, change_next;
  logic       low_reg, low_next;

  logic [7:0] coin_val;
  logic [8:0] coin_sum;
  logic [7:0] eff;
  logic [7:0] price;
  logic [2:0] sel_onehot;
  logic [7:0] sel_stock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      credit_reg   <= '0;
      dispense_reg <= '0;
      refund_reg   <= 1'b0;
      change_reg   <= '0;
      low_reg      <= 1'b0;
      for (int i = 0; i < 3; i++) stock_reg[i] <= 8'(INIT_STOCK);
    end else begin
      state_reg    <= state_next;
      credit_reg   <= credit_next;
      dispense_reg <= dispense_next;
      refund_reg   <= refund_next;
      change_reg   <= change_next;
      low_reg      <= low_next;
      for (int i = 0; i < 3; i++) stock_reg[i] <= stock_next[i];
    end
  end

  always_comb begin
    coin_val      = 8'd0;
    price         = 8'd0;
    sel_onehot    = 3'b000;
    sel_stock     = 8'd0;
    state_next    = state_reg;
    credit_next   = credit_reg;
    dispense_next = 3'b000;
    refund_next   = 1'b0;
    change_next   = 8'd0;
    for (int i = 0; i < 3; i++) stock_next[i] = stock_reg[i];

    case (coin_in)
      2'b01:   coin_val = 8'd5;
      2'b10:   coin_val = 8'd10;
      2'b11:   coin_val = 8'd20;
      default: coin_val = 8'd0;
    endcase

    // A coin that would push credit past the ceiling is swallowed, not refunded.
    coin_sum = {1'b0, credit_reg} + {1'b0, coin_val};
    eff      = (coin_sum > 9'(MAX_CREDIT)) ? credit_reg : coin_sum[7:0];

    case (select_item)
      2'b01:   begin price = 8'(PRICE_A); sel_onehot = 3'b001; sel_stock = stock_reg[0]; end
      2'b10:   begin price = 8'(PRICE_B); sel_onehot = 3'b010; sel_stock = stock_reg[1]; end
      2'b11:   begin price = 8'(PRICE_C); sel_onehot = 3'b100; sel_stock = stock_reg[2]; end
      default: begin price = 8'd0;        sel_onehot = 3'b000; sel_stock = 8'd0;         end
    endcase

    if (cancel) begin
      if (eff != 8'd0) begin
        refund_next = 1'b1;
        change_next = eff;
      end
      credit_next = 8'd0;
      state_next  = IDLE;
    end else if (sel_onehot != 3'b000 && eff >= price && sel_stock != 8'd0) begin
      dispense_next = sel_onehot;
      change_next   = eff - price;
      credit_next   = 8'd0;
      state_next    = IDLE;
      for (int i = 0; i < 3; i++)
        if (sel_onehot[i]) stock_next[i] = stock_reg[i] - 8'd1;
    end else begin
      // Coin only, or a select that failed on credit or stock: keep the credit.
      credit_next = eff;
      state_next  = (eff != 8'd0) ? CREDIT : IDLE;
    end

    low_next = 1'b0;
    for (int i = 0; i < 3; i++)
      if (stock_next[i] <= 8'(LOW_THRESH)) low_next = 1'b1;
  end

  assign dispense_A = dispense_reg[0];
  assign dispense_B = dispense_reg[1];
  assign dispense_C = dispense_reg[2];
  assign refund     = refund_reg;
  assign change_out = change_reg;
  assign low_stock  = low_reg;

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: stimulus pushes expected output events,
// a monitor pops and compares whenever the DUT shows a pulse or non-zero change.
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] coin_in = 2'b00;
  logic [1:0] select_item = 2'b00;
  logic       cancel = 1'b0;
  logic       dispense_A, dispense_B, dispense_C, refund, low_stock;
  logic [7:0] change_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] pulses;   // {A, B, C, refund}
    logic [7:0] change;
    logic       low;
  } exp_t;

  exp_t exp_q [$];

  vending_machine dut (
    .clk(clk), .reset(reset), .coin_in(coin_in), .select_item(select_item),
    .cancel(cancel), .dispense_A(dispense_A), .dispense_B(dispense_B),
    .dispense_C(dispense_C), .refund(refund), .change_out(change_out),
    .low_stock(low_stock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input logic [1:0] c, input logic [1:0] s, input logic x);
    @(negedge clk);
    coin_in = c; select_item = s; cancel = x;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0);
  endtask

  task automatic push(input logic [3:0] p, input int chg, input logic low);
    exp_t e;
    e.pulses = p; e.change = 8'(chg); e.low = low;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    coin_in = 2'b00; select_item = 2'b00; cancel = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pulses", {dispense_A, dispense_B, dispense_C, refund}, 0);
    chk("rst_change", change_out, 0);
    chk("rst_low", low_stock, 0);
    reset = 1'b1;
  endtask

  // Monitor: every cycle with visible output consumes one expected event.
  always @(posedge clk) begin
    #1;
    if (reset && ({dispense_A, dispense_B, dispense_C, refund} != 4'b0 || change_out != 8'd0)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got pulses=%b change=%0d, expected none (t=%0t)",
                 {dispense_A, dispense_B, dispense_C, refund}, change_out, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulses", int'({dispense_A, dispense_B, dispense_C, refund}), int'(e.pulses));
        chk("change", int'(change_out), int'(e.change));
        chk("low_stock", int'(low_stock), int'(e.low));
        $display("txn pulses=%b change=%0d low=%0b", {dispense_A, dispense_B, dispense_C, refund},
                 change_out, low_stock);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Exact payment for A.
    step(2'b10, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b01, 1'b0); push(4'b1000, 0, 1'b0);
    idle(2);

    // B with 5 change.
    do_reset();
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b10, 1'b0); push(4'b0100, 5, 1'b0);
    idle(2);

    // Cancel refunds 15, a later select finds no credit.
    do_reset();
    step(2'b01, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1); push(4'b0001, 15, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    idle(2);

    // Drain item C; low_stock rises on the second vend.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      step(2'b11, 2'b00, 1'b0);
      step(2'b01, 2'b00, 1'b0);
      step(2'b00, 2'b11, 1'b0); push(4'b0010, 0, (r >= 1));
    end
    // Sold out: 25 retained, then spent on B with 5 change.
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    step(2'b00, 2'b10, 1'b0); push(4'b0100, 5, 1'b1);
    idle(2);
    chk("low_held", low_stock, 1);

    // Async reset while a refund pulse is on the outputs.
    for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1); push(4'b0001, 25, 1'b1);
    @(posedge clk);
    #3;
    cancel = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_pulses", {dispense_A, dispense_B, dispense_C, refund}, 0);
    chk("async_change", change_out, 0);
    chk("async_low", low_stock, 0);
    @(negedge clk);
    reset = 1'b1;

    // Credit is zero after reset: select and cancel do nothing.
    step(2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    // Insufficient credit is retained and topped up.
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b01, 1'b0); push(4'b1000, 0, 1'b0);
    idle(2);

    // Credit ceiling: coins past 200 are rejected; cancel beats select.
    do_reset();
    for (int i = 0; i < 10; i++) step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b01, 1'b1); push(4'b0001, 200, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    idle(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
